// File: rtl/buffer_reader.sv
// buffer_reader: claims the newest ready buffer from the sync manager, then streams
// 2^log_length words from memory via AXI4 INCR read bursts to an AXI4-Stream master.
// One burst is outstanding at a time. Read data passes to the stream with zero latency.
module buffer_reader #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [4:0]               log_length,
  output logic                     request,
  input  logic [MM_ADDR_WIDTH-1:0] read_buffer,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [MM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [31:0]              words_q;
  logic [31:0]              remaining_q;
  logic [MM_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]               arlen_q;
  logic [7:0]               beat_cnt_q;
  logic                     error_q;

  logic                     start_ok;
  logic                     in_data;
  logic                     r_fire;
  logic                     last_of_burst;
  logic                     burst_end;
  logic [31:0]              remaining_next;
  logic [MM_ADDR_WIDTH-1:0] burst_bytes;

  // Beats in the next burst, minus one: min(MAX_BURST_LEN, n) - 1, with n >= 1.
  function automatic logic [7:0] burst_arlen(input logic [31:0] n);
    if (n >= 32'(MAX_BURST_LEN)) return 8'(MAX_BURST_LEN - 1);
    else                         return 8'(n - 32'd1);
  endfunction

  assign start_ok       = (state_q == S_IDLE) && start;
  assign in_data        = (state_q == S_DATA);
  assign r_fire         = in_data && m_axi_rvalid && m_axis_tready;
  assign last_of_burst  = (beat_cnt_q == arlen_q);
  assign burst_end      = r_fire && last_of_burst;
  assign remaining_next = remaining_q - 32'd1;
  assign burst_bytes    = (MM_ADDR_WIDTH'(arlen_q) + MM_ADDR_WIDTH'(1)) << BYTE_SHIFT;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; burst boundaries follow the beat counter, never rlast.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   state_d = S_LATCH;
      S_LATCH: state_d = S_ADDR;
      S_ADDR:  if (m_axi_arready) state_d = S_DATA;
      S_DATA:  if (burst_end) state_d = (remaining_next != 32'd0) ? S_ADDR : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read bookkeeping: length, address, remaining words, beat count, sticky error.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      words_q     <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        words_q <= 32'd1 << log_length;
        error_q <= 1'b0;
      end
      // The sync manager has swapped buffers by now, so read_buffer is the claimed one.
      if (state_q == S_LATCH) begin
        remaining_q <= words_q;
        addr_q      <= read_buffer;
        arlen_q     <= burst_arlen(words_q);
      end
      if ((state_q == S_ADDR) && m_axi_arready) beat_cnt_q <= '0;
      if (r_fire) begin
        remaining_q <= remaining_next;
        beat_cnt_q  <= beat_cnt_q + 8'd1;
        if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_of_burst)) error_q <= 1'b1;
      end
      if (burst_end) begin
        addr_q <= addr_q + burst_bytes;
        if (remaining_next != 32'd0) arlen_q <= burst_arlen(remaining_next);
      end
    end
  end

  assign request       = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(BYTE_SHIFT);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == S_ADDR);

  assign m_axi_rready  = in_data && m_axis_tready;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tvalid = in_data && m_axi_rvalid;
  assign m_axis_tlast  = in_data && m_axi_rvalid && (remaining_q == 32'd1);

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader with a small AXI read slave and a stream sink.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_buffer_reader;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  log_length = '0;
  logic        request;
  logic [31:0] read_buffer = '0;
  logic        busy, done, error;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;

  buffer_reader dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .log_length    (log_length),
    .request       (request),
    .read_buffer   (read_buffer),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory contents seen by the slave: a fixed, address-unique pattern.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  // Scenario knobs and observation state shared by the processes below.
  int          cyc = 0;
  logic [31:0] exp_base;
  int          exp_words, exp_idx;
  int          req_cnt, done_cnt, ar_cnt;
  int          last_beat_cyc, done_cyc;
  logic [31:0] ar_addr_log [16];
  logic [7:0]  ar_len_log  [16];
  bit          inj_err = 0, tready_toggle = 0;
  int          ar_delay = 0;
  int          g_beat = 0, n_bursts = 0;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Monitor: counts pulses, logs address handshakes, checks every stream beat.
  initial begin
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    prev_wait = 0;
    prev_addr = '0;
    prev_len  = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_wait = 0;
      end else begin
        if (request) req_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_axi_arvalid && prev_wait) begin
          check("araddr_stable", m_axi_araddr, prev_addr);
          check("arlen_stable", m_axi_arlen, prev_len);
        end
        prev_wait = m_axi_arvalid && !m_axi_arready;
        prev_addr = m_axi_araddr;
        prev_len  = m_axi_arlen;
        if (m_axi_arvalid && m_axi_arready) begin
          if (ar_cnt < 16) begin
            ar_addr_log[ar_cnt] = m_axi_araddr;
            ar_len_log[ar_cnt]  = m_axi_arlen;
          end
          ar_cnt++;
        end
        if (m_axi_rvalid && busy) check("rready_eq_tready", m_axi_rready, m_axis_tready);
        if (m_axis_tvalid && m_axis_tready) begin
          check("tdata", m_axis_tdata, pat(exp_base + 32'(exp_idx * 4)));
          check("tlast", m_axis_tlast, (exp_idx == exp_words - 1));
          if (m_axis_tlast) last_beat_cyc = cyc;
          exp_idx++;
        end
      end
    end
  end

  // AXI read slave and stream sink: one burst at a time, optional arready delay and faults.
  initial begin
    bit          s_ar_fire, s_r_fire, s_ar_seen, b_active;
    logic [31:0] s_araddr, b_addr;
    logic [7:0]  s_arlen, b_len;
    int          beat_k, ar_wait;
    b_active = 0;
    b_addr   = '0;
    b_len    = '0;
    beat_k   = 0;
    ar_wait  = 0;
    forever begin
      @(negedge aclk);
      s_ar_fire = m_axi_arvalid && m_axi_arready;
      s_ar_seen = m_axi_arvalid && !m_axi_arready;
      s_r_fire  = m_axi_rvalid && m_axi_rready;
      s_araddr  = m_axi_araddr;
      s_arlen   = m_axi_arlen;
      @(posedge aclk);
      #1;
      m_axis_tready = tready_toggle ? ~m_axis_tready : 1'b1;
      if (areset) begin
        b_active      = 0;
        ar_wait       = 0;
        m_axi_arready = 1'b0;
      end else begin
        if (s_r_fire) begin
          beat_k++;
          g_beat++;
          if (beat_k > int'(b_len)) b_active = 0;
        end
        if (s_ar_fire) begin
          b_active      = 1;
          b_addr        = s_araddr;
          b_len         = s_arlen;
          beat_k        = 0;
          ar_wait       = 0;
          m_axi_arready = 1'b0;
          n_bursts++;
        end else if (s_ar_seen) begin
          ar_wait++;
          if (ar_wait >= ar_delay) m_axi_arready = 1'b1;
        end
      end
      m_axi_rvalid = b_active;
      m_axi_rdata  = pat(b_addr + 32'(beat_k * 4));
      m_axi_rresp  = (inj_err && b_active && g_beat == 5) ? 2'b10 : 2'b00;
      if (inj_err && n_bursts == 1) m_axi_rlast = b_active && (beat_k == 10);
      else                          m_axi_rlast = b_active && (beat_k == int'(b_len));
    end
  end

  // Arms the scenario, pulses start, then scrambles read_buffer/log_length once latched.
  task automatic start_read(input logic [31:0] base, input logic [4:0] logl,
                            input bit inj, input bit toggle, input int ard);
    read_buffer   = base;
    log_length    = logl;
    exp_base      = base;
    exp_words     = 1 << logl;
    exp_idx       = 0;
    req_cnt       = 0;
    done_cnt      = 0;
    ar_cnt        = 0;
    g_beat        = 0;
    n_bursts      = 0;
    last_beat_cyc = -100;
    done_cyc      = -200;
    inj_err       = inj;
    tready_toggle = toggle;
    ar_delay      = ard;
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    check("error_clear_on_start", error, 0);
    check("busy_after_start", busy, 1);
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    read_buffer = 32'hDEAD_0000;
    log_length  = 5'd2;
  endtask

  // Waits (bounded) for done, optionally firing stray starts while busy and in DONE.
  task automatic wait_done(input bit stray, input bit exp_err);
    bit got;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge aclk);
      if (done) begin
        got   = 1;
        start = stray;
      end else begin
        start = stray && (k == 2 || k == 12);
      end
    end
    @(posedge aclk);
    #1;
    start = 1'b0;
    check("done_seen", got, 1);
    check("idle_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("beat_count", exp_idx, exp_words);
    check("request_pulses", req_cnt, 1);
    check("done_pulses", done_cnt, 1);
    check("done_latency", done_cyc - last_beat_cyc, 1);
    check("error_flag", error, exp_err);
  endtask

  initial begin
    bit reached;
    #1_000_000;
    reached = 0;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    check("rst_request", request, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_arlen", m_axi_arlen, 0);
    check("arsize", m_axi_arsize, 3'd2);
    check("arburst", m_axi_arburst, 2'b01);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // 64 words in four 16-beat bursts.
    start_read(32'h1000_0000, 5'd6, 0, 0, 0);
    wait_done(0, 0);
    check("t1_bursts", ar_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_araddr", ar_addr_log[i], 32'h1000_0000 + 32'(i * 64));
      check("t1_arlen", ar_len_log[i], 8'd15);
    end

    // Single-word buffer.
    start_read(32'h2000_0040, 5'd0, 0, 0, 0);
    wait_done(0, 0);
    check("t2_bursts", ar_cnt, 1);
    check("t2_araddr", ar_addr_log[0], 32'h2000_0040);
    check("t2_arlen", ar_len_log[0], 8'd0);

    // Stream back-pressure every other cycle and slow address channel.
    start_read(32'h3000_0000, 5'd5, 0, 1, 3);
    wait_done(0, 0);
    tready_toggle = 0;
    check("t3_bursts", ar_cnt, 2);
    check("t3_araddr1", ar_addr_log[1], 32'h3000_0040);

    // Bad response and early rlast: sticky error, full buffer still streamed.
    start_read(32'h5000_0000, 5'd5, 1, 0, 0);
    wait_done(0, 1);
    repeat (4) @(posedge aclk);
    #1;
    check("t4_error_sticky", error, 1);
    start_read(32'h5000_0400, 5'd4, 0, 0, 0);
    wait_done(0, 0);

    // Reset in the middle of a burst, then a complete fresh read.
    start_read(32'h6000_0000, 5'd6, 0, 0, 0);
    hit = 0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge aclk);
      #1;
      if (exp_idx >= 7) hit = 1;
    end
    check("t5_reached_beat7", hit, 1);
    areset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_tvalid", m_axis_tvalid, 0);
    check("t5_rready", m_axi_rready, 0);
    check("t5_arvalid", m_axi_arvalid, 0);
    check("t5_araddr", m_axi_araddr, 0);
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    start_read(32'h6000_0000, 5'd6, 0, 0, 0);
    wait_done(0, 0);
    check("t5_bursts", ar_cnt, 4);

    // Stray starts while busy and during DONE are ignored.
    start_read(32'h7000_0000, 5'd4, 0, 0, 0);
    wait_done(1, 0);
    repeat (3) @(posedge aclk);
    #1;
    check("t6_still_idle", busy, 0);
    check("t6_request_pulses", req_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
